// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 32-bit word multiplexer.
//   One of four requesters is granted at a time. The select is registered and
//   drives an internal MUX4T1_32. The selected word is forwarded downstream over
//   a valid/ready handshake. A grant lasts at most MAX_BURST transfers, or ends
//   earlier if the owner drops its request. Every hand-off passes through one
//   IDLE cycle.
//
// Parameters
//   MAX_BURST  transfers per grant before forced release (1..255)
//   CNT_W      beat counter width, must hold MAX_BURST
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   req[3:0]    in   request per requester (req[i] = din_i valid)
//   din0..din3  in   32-bit words of requesters 0..3
//   dout_ready  in   downstream accepts dout this cycle
//   lock        in   (ARB_LOCK_EN only) hold the grant past MAX_BURST
//   gnt[3:0]    out  one-hot grant, registered
//   sel[1:0]    out  index of granted requester, registered, exported
//   dout[31:0]  out  word selected by sel (combinational through the mux)
//   dout_valid  out  dout carries a valid word
//   busy        out  arbiter is in GRANT
//
// Configuration macro
//   ARB_LOCK_EN  adds the lock input. While lock=1 in GRANT, the MAX_BURST
//                release is suppressed and the beat count saturates.
// -----------------------------------------------------------------------------

// Plain 4:1 32-bit word multiplexer shared with other consumers of sel.
module MUX4T1_32 (
  input  logic [1:0]  sel,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  output logic [31:0] y
);
  always_comb begin
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module mux4_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic [31:0] din3,
  input  logic        dout_ready,
`ifdef ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q,   gnt_d;
  logic [1:0]       sel_q,   sel_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] beat_q,  beat_d;

  logic       xfer;
  logic       last_beat;
  logic       burst_rel_ok;
  logic       release_grant;
  logic       pick_valid;
  logic [1:0] pick_idx;

  // Rotating priority scan starting at ptr. The loop walks from the farthest
  // offset down to ptr itself, so the nearest set request is assigned last.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; otherwise a path that skips the assignment infers a latch.
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        pick_valid = 1'b1;
        pick_idx   = ptr_q + 2'(k);
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign burst_rel_ok = ~lock;
`else
  assign burst_rel_ok = 1'b1;
`endif

  assign xfer          = dout_valid & dout_ready;
  assign last_beat     = (beat_q == LAST_BEAT);
  // Withdrawal and the last beat landing together is still one release.
  assign release_grant = ~req[sel_q] | (xfer & last_beat & burst_rel_ok);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_d = IDLE;
          gnt_d   = '0;
          beat_d  = '0;
          ptr_d   = sel_q + 2'd1;
        end else if (xfer && !last_beat) begin
          // On a locked last beat the count saturates instead of wrapping.
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The reset term keeps the reset cycle from counting a beat.
  always_comb begin
    busy       = (state_q == GRANT);
    dout_valid = busy & req[sel_q] & ~rst;
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

  MUX4T1_32 u_mux (
    .sel (sel_q),
    .d0  (din0),
    .d1  (din1),
    .d2  (din2),
    .d3  (din3),
    .y   (dout)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter (MAX_BURST=4). Each record holds one cycle of
// inputs and the outputs expected during that cycle. Inputs are applied 1 ns
// after the rising edge, and outputs are compared on the falling edge.
module tb_mux4_rr_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       lck;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din [4];
  logic        dout_ready;
`ifdef ARB_LOCK_EN
  logic        lock;
`endif
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din0       (din[0]),
    .din1       (din[1]),
    .din2       (din[2]),
    .din3       (din[3]),
    .dout_ready (dout_ready),
`ifdef ARB_LOCK_EN
    .lock       (lock),
`endif
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic rd, input logic lk,
                     input logic [3:0] g, input logic [1:0] s, input logic v, input logic b);
    vec_t e;
    e.rst = r; e.req = rq; e.rdy = rd; e.lck = lk;
    e.gnt = g; e.sel = s; e.valid = v; e.busy = b;
    vecs.push_back(e);
  endtask

  // Apply one record for one cycle and compare all outputs mid-cycle.
  task automatic step(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rst        = v.rst;
    req        = v.req;
    dout_ready = v.rdy;
`ifdef ARB_LOCK_EN
    lock       = v.lck;
`endif
    @(negedge clk);
    check({tag, " gnt"},   32'(gnt),        32'(v.gnt));
    check({tag, " sel"},   32'(sel),        32'(v.sel));
    check({tag, " valid"}, 32'(dout_valid), 32'(v.valid));
    check({tag, " busy"},  32'(busy),       32'(v.busy));
    check({tag, " dout"},  dout,            din[v.sel]);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) step(vecs[i], $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  initial begin
    logic [1:0] owner;
    for (int i = 0; i < 4; i++) din[i] = 32'hA5A5_0000 + 32'(i);
    rst = 1'b1; req = '0; dout_ready = 1'b1;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    repeat (2) @(posedge clk);

    // 1) reset and idle
    add(1, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    // 2) single requester 2: four beats, one IDLE cycle, regrant, withdraw
    add(0, 4'h4, 1, 0, 4'h0, 0, 0, 0);
    for (int b = 0; b < 4; b++) add(0, 4'h4, 1, 0, 4'h4, 2, 1, 1);
    add(0, 4'h4, 1, 0, 4'h0, 2, 0, 0);
    add(0, 4'h0, 1, 0, 4'h4, 2, 0, 1);
    add(1, 4'h0, 1, 0, 4'h0, 2, 0, 0);
    // 3) round-robin wrap 0,1,2,3,0 with all requesting
    add(0, 4'hF, 1, 0, 4'h0, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      owner = 2'(g % 4);
      for (int b = 0; b < 4; b++) add(0, 4'hF, 1, 0, 4'b0001 << owner, owner, 1, 1);
      add(0, (g == 4) ? 4'h0 : 4'hF, 1, 0, 4'h0, owner, 0, 0);
    end
    // 5) owner 3 withdraws after two beats; ptr moves to 0
    add(0, 4'h8, 1, 0, 4'h0, 0, 0, 0);
    add(0, 4'h8, 1, 0, 4'h8, 3, 1, 1);
    add(0, 4'h8, 1, 0, 4'h8, 3, 1, 1);
    add(0, 4'h0, 1, 0, 4'h8, 3, 0, 1);
    add(0, 4'h0, 1, 0, 4'h0, 3, 0, 0);
    add(0, 4'hF, 1, 0, 4'h0, 3, 0, 0);
    add(0, 4'hF, 1, 0, 4'h1, 0, 1, 1);
    // reset mid-burst: valid forced low, then full four-beat burst again
    add(1, 4'hF, 1, 0, 4'h1, 0, 0, 1);
    add(0, 4'h1, 1, 0, 4'h0, 0, 0, 0);
    for (int b = 0; b < 4; b++) add(0, 4'h1, 1, 0, 4'h1, 0, 1, 1);
    add(0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    run_vecs("tbl");

    // 4) backpressure on owner 1: one beat, five stalls, three more beats
    add(1, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    add(0, 4'h2, 1, 0, 4'h0, 0, 0, 0);
    add(0, 4'h2, 1, 0, 4'h2, 1, 1, 1);
    for (int s = 0; s < 5; s++) add(0, 4'h2, 0, 0, 4'h2, 1, 1, 1);
    for (int b = 0; b < 3; b++) add(0, 4'h2, 1, 0, 4'h2, 1, 1, 1);
    add(0, 4'h0, 1, 0, 4'h0, 1, 0, 0);
    run_vecs("bp");

`ifdef ARB_LOCK_EN
    // 6) lock holds owner 0 for ten beats; dropping lock releases on next xfer
    add(1, 4'h0, 1, 0, 4'h0, 0, 0, 0);
    add(0, 4'h3, 1, 1, 4'h0, 0, 0, 0);
    for (int b = 0; b < 10; b++) add(0, 4'h3, 1, 1, 4'h1, 0, 1, 1);
    add(0, 4'h3, 1, 0, 4'h1, 0, 1, 1);
    add(0, 4'h3, 1, 0, 4'h0, 0, 0, 0);
    add(0, 4'h3, 1, 0, 4'h2, 1, 1, 1);
    run_vecs("lock");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
